seg7_capture_decoder: RTL and testbench
=======================================

// Module: seg7_capture_decoder
// PURPOSE
//  Reads the two-digit 7-segment display buses (tens, units) back into numeric
//  form for the digital-clock self-check path. Each bus is synchronised and
//  debounced, and must hold stable for STABLE_CYCLES clocks before it is committed.
//  Committed patterns are decoded to BCD digits and a binary value (0..99).
//  Blank and illegal patterns are flagged, and an update pulse marks value changes.
// PARAMETERS
//  STABLE_CYCLES   16   consecutive identical samples required to commit (>=2)
//  SEG_ACTIVE_LOW  0    1: segment buses are active-low; inverted at input
//  ERR_CNT_W       8    width of saturating illegal-pattern counter
// PORTS
//  clk         in   1          system clock, rising edge
//  rst         in   1          asynchronous reset, active-low
//  led_ten_i   in   7          tens segment bus {g,f,e,d,c,b,a}, bit0 = a
//  led_unit_i  in   7          units segment bus, same mapping
//  tens_o      out  4          committed tens digit, BCD
//  units_o     out  4          committed units digit, BCD
//  value_o     out  7          tens_o*10 + units_o
//  valid_o     out  1          at least one legal value committed since reset
//  upd_o       out  1          1-cycle pulse: committed legal value changed
//  blank_o     out  1          last commit was both digits blank (7'h00)
//  err_o       out  1          last commit contained an illegal pattern
//  err_cnt_o   out  ERR_CNT_W  count of illegal commits, saturating
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0, sync flops 0, FSM=S_WAIT, stab_cnt=0.
//  - Input: 14 bits pass through a 2-flop synchroniser. Bits are inverted first
//    if SEG_ACTIVE_LOW=1. The synchronised word s is compared with its 1-cycle
//    delayed copy p.
//  - FSM S_WAIT / S_LOCK; stab_cnt is $clog2(STABLE_CYCLES) bits wide:
//    s!=p (any state)               -> stab_cnt<=0, state<=S_WAIT
//    S_WAIT, s==p, cnt<STABLE-1     -> stab_cnt++
//    S_WAIT, s==p, cnt==STABLE-1    -> commit s, state<=S_LOCK
//    S_LOCK, s==p                   -> hold; no re-commit, no counting
//  - Latency: outputs change exactly STABLE_CYCLES+3 clocks after a pin change
//    that then stays static. A change that lasts fewer cycles is never committed.
//  - Decode per digit: 3F,06,5B,4F,66,6D,7D,07,7F,6F -> 0..9; 00 -> blank.
//    All other patterns are illegal.
//  - Commit classification (registered, one cycle):
//    both legal digits: tens_o/units_o/value_o load, err_o=0, blank_o=0,
//      valid_o=1; upd_o=1 iff (new value != old value) or valid_o was 0
//    both blank: digits held, blank_o=1, err_o=0, upd_o=0
//    any illegal, or exactly one blank: digits held, err_o=1, blank_o=0,
//      err_cnt_o++ (holds at max), upd_o=0
//  - upd_o is high only in the cycle after a commit. blank_o and err_o hold until
//    the next commit.
//  - value_o is 7 bits wide and at most 99. It is computed with a shift-add
//    (t<<3)+(t<<1)+u; no multiplier.
//  - Reset asserted mid-settle discards the pending sample. After release, the
//    first commit always pulses upd_o if it is legal.
// STRUCTURE
//  - seg7_pkg: segment pattern localparams SEG_0..SEG_9 and SEG_BLANK, FSM state
//    encodings, and the digit-code enum {DIG_0..DIG_9, DIG_BLANK, DIG_ILL}.
//  - Sub-module seg7_pattern_decode (combinational, 7b -> 4b digit + blank +
//    illegal), instantiated twice. The FSM, synchroniser, counters and output
//    registers stay in this top.
// TESTING
//  1 Reset: rst=0 mid-run -> all outputs 0 immediately; valid_o=0.
//  2 Drive ten=7'h5B, unit=7'h6D, held, STABLE_CYCLES=16 -> after 19 clocks
//    tens_o=2, units_o=5, value_o=25, valid_o=1, upd_o high for exactly 1 cycle.
//  3 Glitch: units toggles to 7'h7F for 10 cycles then back to 7'h6D -> no
//    commit, no upd_o, value_o stays 25.
//  4 Same value re-presented after a 30-cycle excursion to 25 again -> commit
//    occurs with upd_o=0. Then drive 9,9 (6F,6F) -> value_o=99, upd_o pulses.
//  5 Illegal unit=7'h01 held -> err_o=1, err_cnt_o=1, digits held. 300 illegal
//    commits -> err_cnt_o saturates at 255.
//  6 Both 7'h00 -> blank_o=1, digits held. SEG_ACTIVE_LOW=1 with ten=~7'h3F,
//    unit=~7'h06 -> value_o=1.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared segment patterns, FSM states and digit codes
// for the 7-segment readback path.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_LOCK = 1'b1
  } state_e;

  typedef enum logic [3:0] {
    DIG_0     = 4'd0,
    DIG_1     = 4'd1,
    DIG_2     = 4'd2,
    DIG_3     = 4'd3,
    DIG_4     = 4'd4,
    DIG_5     = 4'd5,
    DIG_6     = 4'd6,
    DIG_7     = 4'd7,
    DIG_8     = 4'd8,
    DIG_9     = 4'd9,
    DIG_BLANK = 4'd10,
    DIG_ILL   = 4'd11
  } dig_e;

  function automatic dig_e seg_decode(
    input logic [6:0] seg
  );
    dig_e d;
    d = DIG_ILL;
    case (seg)
      SEG_0:     d = DIG_0;
      SEG_1:     d = DIG_1;
      SEG_2:     d = DIG_2;
      SEG_3:     d = DIG_3;
      SEG_4:     d = DIG_4;
      SEG_5:     d = DIG_5;
      SEG_6:     d = DIG_6;
      SEG_7:     d = DIG_7;
      SEG_8:     d = DIG_8;
      SEG_9:     d = DIG_9;
      SEG_BLANK: d = DIG_BLANK;
      default:   d = DIG_ILL;
    endcase
    return d;
  endfunction

  // t*10 + u as (t<<3)+(t<<1)+u, max 99
  function automatic logic [6:0] bcd_to_bin(
    input logic [3:0] t,
    input logic [3:0] u
  );
    logic [6:0] tw;
    tw = {3'b000, t};
    return (tw << 3) + (tw << 1) + {3'b000, u};
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to BCD digit decoder
// with blank and illegal flags.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] digit_o,
  output logic       blank_o,
  output logic       illegal_o
);

  dig_e code;

  always_comb begin
    code      = seg_decode(seg_i);
    blank_o   = (code == DIG_BLANK);
    illegal_o = (code == DIG_ILL);
    digit_o   = 4'd0;
    if (!blank_o && !illegal_o) begin
      digit_o = 4'(code);
    end
  end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Two-digit 7-segment bus readback: sync, debounce,
// commit, decode and classify into BCD/binary value.
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           led_ten_i,
  input  logic [6:0]           led_unit_i,
  output logic [3:0]           tens_o,
  output logic [3:0]           units_o,
  output logic [6:0]           value_o,
  output logic                 valid_o,
  output logic                 upd_o,
  output logic                 blank_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(STABLE_CYCLES - 1);

  logic [13:0] raw;
  logic [13:0] sync1_q;
  logic [13:0] s_q;
  logic [13:0] p_q;

  assign raw = {led_ten_i, led_unit_i}
             ^ {14{SEG_ACTIVE_LOW}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      s_q     <= '0;
      p_q     <= '0;
    end else begin
      sync1_q <= raw;
      s_q     <= sync1_q;
      p_q     <= s_q;
    end
  end

  logic [3:0] t_dig;
  logic [3:0] u_dig;
  logic       t_blank;
  logic       u_blank;
  logic       t_ill;
  logic       u_ill;

  seg7_pattern_decode u_dec_ten (
    .seg_i     (s_q[13:7]),
    .digit_o   (t_dig),
    .blank_o   (t_blank),
    .illegal_o (t_ill)
  );

  seg7_pattern_decode u_dec_unit (
    .seg_i     (s_q[6:0]),
    .digit_o   (u_dig),
    .blank_o   (u_blank),
    .illegal_o (u_ill)
  );

  logic                 same;
  logic                 both_legal;
  logic                 both_blank;
  logic [6:0]           value_d;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  assign same       = (s_q == p_q);
  assign both_legal = !t_blank && !t_ill
                    && !u_blank && !u_ill;
  assign both_blank = t_blank && u_blank;
  assign value_d    = bcd_to_bin(t_dig, u_dig);

  state_e               state_q;
  logic [CNT_W-1:0]     stab_cnt_q;
  logic [3:0]           tens_q;
  logic [3:0]           units_q;
  logic [6:0]           value_q;
  logic                 valid_q;
  logic                 upd_q;
  logic                 blank_q;
  logic                 err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  assign err_cnt_d = (err_cnt_q == '1)
                   ? err_cnt_q
                   : err_cnt_q + ERR_CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_WAIT;
      stab_cnt_q <= '0;
      tens_q     <= '0;
      units_q    <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      upd_q      <= 1'b0;
      blank_q    <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      upd_q <= 1'b0;
      if (!same) begin
        stab_cnt_q <= '0;
        state_q    <= S_WAIT;
      end else if (state_q == S_WAIT) begin
        if (stab_cnt_q != CNT_MAX) begin
          stab_cnt_q <= stab_cnt_q + CNT_W'(1);
        end else begin
          state_q    <= S_LOCK;
          stab_cnt_q <= '0;
          unique case (1'b1)
            both_legal: begin
              tens_q  <= t_dig;
              units_q <= u_dig;
              value_q <= value_d;
              valid_q <= 1'b1;
              blank_q <= 1'b0;
              err_q   <= 1'b0;
              upd_q   <= (value_d != value_q)
                       || !valid_q;
            end
            both_blank: begin
              blank_q <= 1'b1;
              err_q   <= 1'b0;
            end
            default: begin
              blank_q   <= 1'b0;
              err_q     <= 1'b1;
              err_cnt_q <= err_cnt_d;
            end
          endcase
        end
      end
    end
  end

  assign tens_o    = tens_q;
  assign units_o   = units_q;
  assign value_o   = value_q;
  assign valid_o   = valid_q;
  assign upd_o     = upd_q;
  assign blank_o   = blank_q;
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Self-checking bench for seg7_capture_decoder: table of
// commits through a scoreboard queue plus corner sequences.
module tb_seg7_capture_decoder;

  typedef struct {
    logic [6:0] ten;
    logic [6:0] unit;
    logic [3:0] t;
    logic [3:0] u;
    logic [6:0] v;
    logic       valid;
    logic       upd;
    logic       blank;
    logic       err;
    logic [7:0] ecnt;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [6:0] ten;
  logic [6:0] unit;
  logic [3:0] tens_o;
  logic [3:0] units_o;
  logic [6:0] value_o;
  logic       valid_o;
  logic       upd_o;
  logic       blank_o;
  logic       err_o;
  logic [7:0] err_cnt_o;

  logic [6:0] ten_n;
  logic [6:0] unit_n;
  logic [3:0] tens_n;
  logic [3:0] units_n;
  logic [6:0] value_n;
  logic       valid_n;
  logic       upd_n;
  logic       blank_n;
  logic       err_n;
  logic [7:0] err_cnt_n;

  int   n_tests;
  int   n_fail;
  vec_t exp_q[$];
  vec_t tbl[14];

  seg7_capture_decoder #(
    .STABLE_CYCLES  (16),
    .SEG_ACTIVE_LOW (1'b0),
    .ERR_CNT_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .led_ten_i  (ten),
    .led_unit_i (unit),
    .tens_o     (tens_o),
    .units_o    (units_o),
    .value_o    (value_o),
    .valid_o    (valid_o),
    .upd_o      (upd_o),
    .blank_o    (blank_o),
    .err_o      (err_o),
    .err_cnt_o  (err_cnt_o)
  );

  seg7_capture_decoder #(
    .STABLE_CYCLES  (4),
    .SEG_ACTIVE_LOW (1'b1),
    .ERR_CNT_W      (8)
  ) dut_n (
    .clk        (clk),
    .rst        (rst),
    .led_ten_i  (ten_n),
    .led_unit_i (unit_n),
    .tens_o     (tens_n),
    .units_o    (units_n),
    .value_o    (value_n),
    .valid_o    (valid_n),
    .upd_o      (upd_n),
    .blank_o    (blank_n),
    .err_o      (err_n),
    .err_cnt_o  (err_cnt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".tens"},  32'(tens_o), 0);
    chk({nm, ".units"}, 32'(units_o), 0);
    chk({nm, ".value"}, 32'(value_o), 0);
    chk({nm, ".valid"}, 32'(valid_o), 0);
    chk({nm, ".upd"},   32'(upd_o), 0);
    chk({nm, ".blank"}, 32'(blank_o), 0);
    chk({nm, ".err"},   32'(err_o), 0);
    chk({nm, ".ecnt"},  32'(err_cnt_o), 0);
  endtask

  // Pin change lands between edges; commit shows after edge 19
  task automatic wait_and_check(input string nm);
    vec_t e;
    repeat (18) @(posedge clk);
    #1;
    chk({nm, ".upd_early"}, 32'(upd_o), 0);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({nm, ".queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk({nm, ".tens"},  32'(tens_o), 32'(e.t));
      chk({nm, ".units"}, 32'(units_o), 32'(e.u));
      chk({nm, ".value"}, 32'(value_o), 32'(e.v));
      chk({nm, ".valid"}, 32'(valid_o), 32'(e.valid));
      chk({nm, ".upd"},   32'(upd_o), 32'(e.upd));
      chk({nm, ".blank"}, 32'(blank_o), 32'(e.blank));
      chk({nm, ".err"},   32'(err_o), 32'(e.err));
      chk({nm, ".ecnt"},  32'(err_cnt_o), 32'(e.ecnt));
    end
    @(posedge clk);
    #1;
    chk({nm, ".upd_width"}, 32'(upd_o), 0);
  endtask

  task automatic drive_and_check(
    input string nm,
    input vec_t  e
  );
    @(negedge clk);
    ten  = e.ten;
    unit = e.unit;
    exp_q.push_back(e);
    wait_and_check(nm);
  endtask

  initial begin
    vec_t e;
    logic saw_upd;
    logic bad_val;

    n_tests = 0;
    n_fail  = 0;

    tbl[0]  = '{7'h5B, 7'h6D, 2, 5, 25, 1, 1, 0, 0, 0};
    tbl[1]  = '{7'h6F, 7'h6F, 9, 9, 99, 1, 1, 0, 0, 0};
    tbl[2]  = '{7'h3F, 7'h06, 0, 1, 1,  1, 1, 0, 0, 0};
    tbl[3]  = '{7'h00, 7'h00, 0, 1, 1,  1, 0, 1, 0, 0};
    tbl[4]  = '{7'h3F, 7'h06, 0, 1, 1,  1, 0, 0, 0, 0};
    tbl[5]  = '{7'h00, 7'h06, 0, 1, 1,  1, 0, 0, 1, 1};
    tbl[6]  = '{7'h7D, 7'h01, 0, 1, 1,  1, 0, 0, 1, 2};
    tbl[7]  = '{7'h4F, 7'h66, 3, 4, 34, 1, 1, 0, 0, 2};
    tbl[8]  = '{7'h7F, 7'h07, 8, 7, 87, 1, 1, 0, 0, 2};
    tbl[9]  = '{7'h07, 7'h7F, 7, 8, 78, 1, 1, 0, 0, 2};
    tbl[10] = '{7'h66, 7'h5B, 4, 2, 42, 1, 1, 0, 0, 2};
    tbl[11] = '{7'h6D, 7'h4F, 5, 3, 53, 1, 1, 0, 0, 2};
    tbl[12] = '{7'h3F, 7'h3F, 0, 0, 0,  1, 1, 0, 0, 2};
    tbl[13] = '{7'h06, 7'h00, 0, 0, 0,  1, 0, 0, 1, 3};

    rst    = 1'b0;
    ten    = 7'h00;
    unit   = 7'h00;
    ten_n  = 7'h7F;
    unit_n = 7'h7F;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive_and_check($sformatf("vec%0d", i), tbl[i]);
    end

    // glitch on units must not commit
    e = '{7'h5B, 7'h6D, 2, 5, 25, 1, 1, 0, 0, 3};
    drive_and_check("set25", e);
    @(negedge clk);
    unit = 7'h7F;
    repeat (10) @(negedge clk);
    unit = 7'h6D;
    saw_upd = 1'b0;
    bad_val = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (upd_o) saw_upd = 1'b1;
      if (value_o != 7'd25) bad_val = 1'b1;
    end
    chk("glitch.upd", 32'(saw_upd), 0);
    chk("glitch.value", 32'(bad_val), 0);
    chk("glitch.ecnt", 32'(err_cnt_o), 3);

    // blank excursion, then same value again: no update
    @(negedge clk);
    ten  = 7'h00;
    unit = 7'h00;
    repeat (30) @(posedge clk);
    #1;
    chk("excur.blank", 32'(blank_o), 1);
    chk("excur.value", 32'(value_o), 25);
    e = '{7'h5B, 7'h6D, 2, 5, 25, 1, 0, 0, 0, 3};
    drive_and_check("same25", e);
    e = '{7'h6F, 7'h6F, 9, 9, 99, 1, 1, 0, 0, 3};
    drive_and_check("to99", e);

    // reset mid-settle discards pending sample
    @(negedge clk);
    ten  = 7'h3F;
    unit = 7'h3F;
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    e = '{7'h3F, 7'h3F, 0, 0, 0, 1, 1, 0, 0, 0};
    exp_q.push_back(e);
    wait_and_check("post_rst");

    // illegal commits and counter saturation
    e = '{7'h3F, 7'h01, 0, 0, 0, 1, 0, 0, 1, 1};
    drive_and_check("ill1", e);
    for (int i = 2; i <= 300; i++) begin
      @(negedge clk);
      unit = i[0] ? 7'h01 : 7'h02;
      repeat (20) @(posedge clk);
      #1;
      if (i == 254 || i == 255) begin
        chk($sformatf("sat%0d", i),
            32'(err_cnt_o), 32'(i));
      end
    end
    chk("sat.ecnt", 32'(err_cnt_o), 255);
    chk("sat.err", 32'(err_o), 1);
    chk("sat.value", 32'(value_o), 0);
    chk("sat.valid", 32'(valid_o), 1);

    e = '{7'h00, 7'h00, 0, 0, 0, 1, 0, 1, 0, 255};
    drive_and_check("blank", e);

    // active-low instance, STABLE_CYCLES=4 -> 7 clocks
    chk("n.blank0", 32'(blank_n), 1);
    @(negedge clk);
    ten_n  = ~7'h3F;
    unit_n = ~7'h06;
    repeat (6) @(posedge clk);
    #1;
    chk("n.upd_early", 32'(upd_n), 0);
    @(posedge clk);
    #1;
    chk("n.value", 32'(value_n), 1);
    chk("n.tens", 32'(tens_n), 0);
    chk("n.units", 32'(units_n), 1);
    chk("n.valid", 32'(valid_n), 1);
    chk("n.upd", 32'(upd_n), 1);
    chk("n.blank", 32'(blank_n), 0);
    chk("n.err", 32'(err_n), 0);
    chk("n.ecnt", 32'(err_cnt_n), 0);
    @(posedge clk);
    #1;
    chk("n.upd_width", 32'(upd_n), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
